// File: rtl/hbm_edge_addr_gen.sv
// Per-pseudo-channel edge-address generator: expands [loff, roff) edge ranges
// into one word-aligned HBM read address per cycle, throttled by stage_full.
module hbm_edge_addr_gen #(
   parameter int                    HBM_AWIDTH = 33,
   parameter int                    OFF_WIDTH  = 32,
   parameter int                    EDGE_SHIFT = 4,
   parameter int                    ADDR_SHIFT = 6,
   parameter logic [HBM_AWIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [OFF_WIDTH-1:0]  front_loff,
   input  logic [OFF_WIDTH-1:0]  front_roff,
   input  logic                  front_valid,
   output logic                  front_ready,
   input  logic                  stage_full,
   output logic [HBM_AWIDTH-1:0] rd_hbm_edge_addr,
   output logic                  rd_hbm_edge_valid,
   output logic                  idle,
   output logic                  range_err,
   output logic [CNT_WIDTH-1:0]  issued_cnt
);
   localparam int WW = OFF_WIDTH - EDGE_SHIFT;

   typedef enum logic {S_IDLE, S_ISSUE} state_e;

   state_e                  state_q, state_d;
   logic [WW-1:0]           cur_q, cur_d, last_q, last_d;
   logic [HBM_AWIDTH-1:0]   addr_q, addr_d;
   logic                    vld_q, vld_d, err_q, err_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

   function automatic logic [HBM_AWIDTH-1:0] word_addr(input logic [WW-1:0] w);
      return BASE_ADDR + (HBM_AWIDTH'(w) << ADDR_SHIFT);
   endfunction

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      addr_d      = addr_q;
      vld_d       = 1'b0;
      cnt_d       = cnt_q;
      err_d       = err_q;
      front_ready = 1'b0;
      case (state_q)
         S_IDLE: front_ready = 1'b1;
         S_ISSUE: begin
            if (!stage_full) begin
               vld_d  = 1'b1;
               addr_d = word_addr(cur_q);
               cnt_d  = cnt_q + CNT_WIDTH'(1);
               // Last word goes out this cycle: open the front door now so the
               // next range follows with no bubble.
               if (cur_q == last_q) begin
                  front_ready = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  cur_d = cur_q + WW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (front_ready && front_valid) begin
         if (front_loff < front_roff) begin
            state_d = S_ISSUE;
            cur_d   = front_loff[OFF_WIDTH-1:EDGE_SHIFT];
            last_d  = WW'((front_roff - OFF_WIDTH'(1)) >> EDGE_SHIFT);
         end else if (front_loff > front_roff) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         addr_q  <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign rd_hbm_edge_addr  = addr_q;
   assign rd_hbm_edge_valid = vld_q;
   assign range_err         = err_q;
   assign issued_cnt        = cnt_q;
   assign idle              = (state_q == S_IDLE) && !vld_q;

endmodule

// File: tb/tb_hbm_edge_addr_gen.sv
// Bench for hbm_edge_addr_gen: table vectors, hand corner sequences and random
// traffic, all checked against a queue-of-pending-words reference model.
module tb_hbm_edge_addr_gen;
   localparam longint MASK  = 64'h1_FFFF_FFFF;
   localparam longint BASE1 = 64'h1_FFFF_FFC0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] front_loff, front_roff;
   logic        front_valid, stage_full;
   logic        rdy0, vld0, idle0, err0, rdy1, vld1, idle1, err1;
   logic [32:0] addr0, addr1;
   logic [31:0] cnt0, cnt1;

   hbm_edge_addr_gen u0 (
      .clk(clk), .rst(rst), .front_loff(front_loff), .front_roff(front_roff),
      .front_valid(front_valid), .front_ready(rdy0), .stage_full(stage_full),
      .rd_hbm_edge_addr(addr0), .rd_hbm_edge_valid(vld0), .idle(idle0),
      .range_err(err0), .issued_cnt(cnt0));

   hbm_edge_addr_gen #(.BASE_ADDR(33'h1_FFFF_FFC0)) u1 (
      .clk(clk), .rst(rst), .front_loff(front_loff), .front_roff(front_roff),
      .front_valid(front_valid), .front_ready(rdy1), .stage_full(stage_full),
      .rd_hbm_edge_addr(addr1), .rd_hbm_edge_valid(vld1), .idle(idle1),
      .range_err(err1), .issued_cnt(cnt1));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: words still owed, plus the registered output it implies.
   longint pend[$];
   longint obs[$];
   bit     m_vld, m_err, m_rdy;
   longint m_addr;
   longint m_cnt;

   function automatic void chk(input string n, input longint a, input longint e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
      end
   endfunction

   function automatic void model_reset();
      pend.delete();
      m_vld = 0; m_err = 0; m_addr = 0; m_cnt = 0;
   endfunction

   // One cycle starting and ending at a falling edge.
   task automatic step(input bit v, input int lo, input int ro, input bit sf);
      front_valid = v; front_loff = lo; front_roff = ro; stage_full = sf;
      #1;
      m_rdy = (pend.size() == 0) || (pend.size() == 1 && !sf);
      chk("front_ready", rdy0, m_rdy);
      chk("front_ready_b", rdy1, m_rdy);
      @(posedge clk);
      if (pend.size() > 0 && !sf) begin
         m_vld = 1; m_addr = pend.pop_front(); m_cnt = (m_cnt + 1) & 64'hFFFF_FFFF;
      end else begin
         m_vld = 0;
      end
      if (v && m_rdy) begin
         if (lo < ro)
            for (int w = lo >> 4; w <= (ro - 1) >> 4; w++) pend.push_back(longint'(w) << 6);
         else if (lo > ro)
            m_err = 1;
      end
      #1;
      chk("valid", vld0, m_vld);
      chk("valid_b", vld1, m_vld);
      if (m_vld) begin
         chk("addr", addr0, m_addr);
         chk("addr_b", addr1, (m_addr + BASE1) & MASK);
         obs.push_back(addr0);
      end
      chk("issued_cnt", cnt0, m_cnt);
      chk("range_err", err0, m_err);
      chk("idle", idle0, pend.size() == 0 && !m_vld);
      chk("idle_b", idle1, idle0);
      chk("cnt_b", cnt1, cnt0);
      chk("err_b", err1, err0);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && !(pend.size() == 0 && !m_vld); i++) step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("drain_idle", idle0, 1);
   endtask

   typedef struct {
      int     lo;
      int     ro;
      int     n;
      longint first;
      bit     err;
   } vec_t;
   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      longint c0;
      tbl[0] = '{0,   40,  3,  64'h0,   0};
      tbl[1] = '{15,  17,  2,  64'h0,   0};
      tbl[2] = '{16,  16,  0,  64'h0,   0};
      tbl[3] = '{32,  48,  1,  64'h80,  0};
      tbl[4] = '{100, 300, 13, 64'h180, 0};
      tbl[5] = '{20,  10,  0,  64'h0,   1};

      rst = 0; front_valid = 0; front_loff = 0; front_roff = 0; stage_full = 0;
      model_reset();
      #12;
      chk("rst_valid", vld0, 0);
      chk("rst_addr", addr0, 0);
      chk("rst_cnt", cnt0, 0);
      chk("rst_err", err0, 0);
      chk("rst_ready", rdy0, 1);
      chk("rst_idle", idle0, 1);
      @(negedge clk);
      rst = 1;

      foreach (tbl[i]) begin
         obs.delete();
         c0 = m_cnt;
         step(1, tbl[i].lo, tbl[i].ro, 0);
         drain();
         chk("tbl_count", obs.size(), tbl[i].n);
         chk("tbl_cnt_delta", cnt0 - c0, tbl[i].n);
         if (tbl[i].n > 0) chk("tbl_first", obs[0], tbl[i].first);
         chk("tbl_err", err0, tbl[i].err);
      end

      // Backpressure on the 2nd and 3rd issue cycles.
      obs.delete();
      step(1, 0, 64, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("bp_stall1", vld0, 0);
      step(0, 0, 0, 1);
      chk("bp_stall2", vld0, 0);
      drain();
      chk("bp_n", obs.size(), 4);
      for (int i = 0; i < 4 && i < obs.size(); i++) chk("bp_seq", obs[i], longint'(i) << 6);

      // Back-to-back ranges: no bubble between them.
      step(1, 0, 16, 0);
      step(1, 32, 48, 0);
      chk("b2b_first", {vld0, addr0}, {1'b1, 33'h0});
      step(0, 0, 0, 0);
      chk("b2b_second", {vld0, addr0}, {1'b1, 33'h80});
      drain();

      // Base address wrap on the second instance.
      step(1, 16, 32, 0);
      step(0, 0, 0, 0);
      chk("wrap_addr", {vld1, addr1}, {1'b1, 33'h0});
      drain();

      // Asynchronous reset in the middle of a 10-word range.
      step(1, 0, 160, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      #2;
      rst = 0;
      #1;
      chk("arst_valid", vld0, 0);
      chk("arst_cnt", cnt0, 0);
      chk("arst_idle", idle0, 1);
      model_reset();
      @(negedge clk);
      rst = 1;
      obs.delete();
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
      chk("arst_no_stale", obs.size(), 0);

      // Random traffic, including offers while not ready and stalls.
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 1), $urandom_range(0, 200), $urandom_range(0, 260),
              $urandom_range(0, 9) < 3);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hbm_edge_addr_gen.md
Name: hbm_edge_addr_gen

Overview:
- Per-pseudo-channel edge-address generator, directly upstream of the HBM request stage.
- Takes one active vertex's edge range (left/right edge offset) per handshake and expands it into one HBM word read address per cycle.
- Its address/valid outputs drive the request stage's front_rd_hbm_edge_addr/front_rd_hbm_edge_valid; that stage's stage_full (a prog_full) throttles issue.
- One instance per pseudo channel.

Parameters:
- HBM_AWIDTH, 33, byte address width of rd_hbm_edge_addr.
- OFF_WIDTH, 32, width of edge offsets (units of edges).
- EDGE_SHIFT, 4, log2 of edges per HBM word (512-bit word, 32-bit edge).
- ADDR_SHIFT, 6, log2 of bytes per HBM word.
- BASE_ADDR, 0, byte base of the channel's edge region, added to every address.
- CNT_WIDTH, 32, width of the issued-request counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- front_loff  in  OFF_WIDTH  first edge offset of range (inclusive).
- front_roff  in  OFF_WIDTH  end edge offset of range (exclusive).
- front_valid  in  1  range valid.
- front_ready  out  1  range accepted when front_valid && front_ready.
- stage_full  in  1  downstream request FIFO prog_full.
- rd_hbm_edge_addr  out  HBM_AWIDTH  word-aligned byte read address.
- rd_hbm_edge_valid  out  1  address valid, single-cycle per address.
- idle  out  1  high in IDLE with no pending output.
- range_err  out  1  sticky: a range with loff > roff was received.
- issued_cnt  out  CNT_WIDTH  count of addresses issued since reset.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; rd_hbm_edge_addr=0, rd_hbm_edge_valid=0, issued_cnt=0, range_err=0, internal cur/last=0. Outputs: front_ready=1, idle=1 (combinational from IDLE).
- Reset asserted mid-range: range is abandoned, no further addresses. The range is not resumed after release.
- Word range: first_w = loff >> EDGE_SHIFT; last_w = (roff-1) >> EDGE_SHIFT. Both are OFF_WIDTH-EDGE_SHIFT bits, unsigned.
- Address: rd_hbm_edge_addr = BASE_ADDR + (w << ADDR_SHIFT). Zero-extend or truncate to HBM_AWIDTH; the sum wraps modulo 2^HBM_AWIDTH.
- States:
  - IDLE: front_ready=1. On accept with loff<roff, latch cur=first_w, last=last_w, go ISSUE.
  - IDLE, accept with loff==roff: range consumed, no address, stay IDLE.
  - IDLE, accept with loff>roff: same as empty, and set range_err.
  - ISSUE, stage_full=0: register rd_hbm_edge_valid=1 with the address of cur; issued_cnt += 1 (wraps). If cur==last, the range is complete; otherwise cur += 1.
  - ISSUE, stage_full=1: rd_hbm_edge_valid=0 next cycle; cur is held. No address is skipped or duplicated.
  - Range complete: front_ready=1 in that same cycle, so the next range is accepted back-to-back. Nonempty next range: stay ISSUE with the new cur/last. Empty next range, or no front_valid: go IDLE.
  - ISSUE otherwise: front_ready=0.
- Latency: a range accepted in cycle N has its first address valid in cycle N+1, provided stage_full=0 in cycle N+1's issue decision.
- Throughput: one address per cycle, including across back-to-back ranges (no bubble).
- stage_full is a prog_full, so the one-cycle registered issue after assertion is tolerated. At most one address is presented in the cycle after stage_full rises.
- idle = (state==IDLE) && !rd_hbm_edge_valid.
- front_* inputs are ignored when front_ready=0.

Test Plan:
- Single range (BASE_ADDR=0): loff=0, roff=40, stage_full=0 → addresses 0x0, 0x40, 0x80 in cycles N+1..N+3; issued_cnt=3; idle high at N+4.
- Unaligned range: loff=15, roff=17 → addresses 0x0 and 0x40. Range loff=16, roff=16 → no address, front_ready stays 1, range_err=0.
- Backpressure: loff=0, roff=64 with stage_full high for the 2nd and 3rd issue cycles → exactly 0x0, 0x40, 0x80, 0xC0, once each, in order; no valid while stalled.
- Back-to-back: ranges [0,16) then [32,48) offered consecutively → 0x0 in cycle N+1 and 0x80 in cycle N+2, no gap.
- Error and wrap: loff=20, roff=10 → no address, range_err=1 and held. BASE_ADDR=2^33-0x40 with loff=16, roff=32 → address 0x0.
- Async reset mid-range: drop rst during a 10-word range after 3 issues → valid=0 and issued_cnt=0 immediately without a clock edge; after release, idle=1 and no stale addresses.
